// File: rtl/div_if.sv
// ----------------------------------------------------------------------------
// div_if
// Purpose : Groups the request and response signals between the execute
//           stage and the iterative divider into one bundle.
// Signals : start     - request a divide/remainder op (sampled while idle)
//           op        - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//           dividend  - rs1 value, sampled with start
//           divisor   - rs2 value, sampled with start
//           flush     - synchronous abort of any in-flight operation
//           busy      - divider is iterating, the pipeline must stall
//           done      - one-cycle pulse, result is valid
//           result    - quotient or remainder, held until the next done
// Modports: master drives the request side (execute stage / testbench),
//           slave is the divider itself.
// ----------------------------------------------------------------------------
interface div_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
// Purpose : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//           Signed ops divide the magnitudes and fix the sign at the end.
//           Divide-by-zero and signed overflow finish one cycle after start
//           without iterating; all other ops finish XLEN+1 cycles after start.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous, active-high reset
//           bus   - div_if slave modport (start/op/dividend/divisor/flush in,
//                   busy/done/result out)
// ----------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic  clk,
  input  logic  reset,
  div_if.slave  bus
);

  localparam int              CW   = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic {
    IDLE,
    DIVIDE
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN:0]   r_rem;
  logic [CW-1:0]   r_count;
  logic            r_negQ;
  logic            r_negR;
  logic            r_isRem;

  // Operand conditioning at start: op[0]=0 selects the signed variants,
  // whose operands are reduced to magnitudes before iterating.
  logic            w_signedOp;
  logic            w_dvdNeg;
  logic            w_dvsNeg;
  logic [XLEN-1:0] w_absDvd;
  logic [XLEN-1:0] w_absDvs;
  logic            w_divZero;
  logic            w_overflow;

  assign w_signedOp = ~bus.op[0];
  assign w_dvdNeg   = w_signedOp & bus.dividend[XLEN-1];
  assign w_dvsNeg   = w_signedOp & bus.divisor[XLEN-1];
  assign w_absDvd   = w_dvdNeg ? -bus.dividend : bus.dividend;
  assign w_absDvs   = w_dvsNeg ? -bus.divisor  : bus.divisor;
  assign w_divZero  = (bus.divisor == '0);
  assign w_overflow = w_signedOp & (bus.dividend == MINV) & (bus.divisor == '1);

  // One restoring step. The quotient register doubles as the dividend shift
  // register: its MSB feeds the partial remainder while the new quotient bit
  // enters at the LSB. The subtraction is one bit wider than the remainder
  // register so its top bit is the borrow (negative difference).
  logic [XLEN+1:0] w_shifted;
  logic [XLEN+1:0] w_diff;
  logic            w_qBit;
  logic [XLEN:0]   w_remNext;
  logic [XLEN-1:0] w_quotNext;
  logic [XLEN-1:0] w_finalQ;
  logic [XLEN-1:0] w_finalR;

  assign w_shifted  = {r_rem, r_quot[XLEN-1]};
  assign w_diff     = w_shifted - {2'b00, r_divisor};
  assign w_qBit     = ~w_diff[XLEN+1];
  assign w_remNext  = w_qBit ? w_diff[XLEN:0] : w_shifted[XLEN:0];
  assign w_quotNext = {r_quot[XLEN-2:0], w_qBit};
  assign w_finalQ   = r_negQ ? -w_quotNext : w_quotNext;
  assign w_finalR   = r_negR ? -w_remNext[XLEN-1:0] : w_remNext[XLEN-1:0];

  // Control FSM and datapath registers. flush takes priority over a start
  // in the same cycle; result is only touched when done is raised so it
  // survives a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_isRem   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              r_isRem <= bus.op[1];
              if (w_divZero) begin
                r_result <= bus.op[1] ? bus.dividend : '1;
                r_done   <= 1'b1;
              end else if (w_overflow) begin
                r_result <= bus.op[1] ? '0 : MINV;
                r_done   <= 1'b1;
              end else begin
                r_quot    <= w_absDvd;
                r_divisor <= w_absDvs;
                r_rem     <= '0;
                r_negQ    <= w_dvdNeg ^ w_dvsNeg;
                r_negR    <= w_dvdNeg;
                r_count   <= '0;
                r_busy    <= 1'b1;
                r_state   <= DIVIDE;
              end
            end
          end
          DIVIDE: begin
            r_quot  <= w_quotNext;
            r_rem   <= w_remNext;
            r_count <= r_count + 1'b1;
            if (r_count == LAST) begin
              r_result <= r_isRem ? w_finalR : w_finalQ;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage, directly downstream of the decode-stage control unit.
- The execute stage raises `start` when a decoded M-extension divide/remainder op arrives. It stalls the pipeline while `busy` is high and captures `result` on `done`.
- Multiply ops are handled elsewhere.

Parameters:
- XLEN, 32, operand/result width in bits; the iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock; the block's single clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only while busy=0.
- op  input  2  funct3[1:0] of the instruction: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  XLEN  rs1 value; sampled with start.
- divisor  input  XLEN  rs2 value; sampled with start.
- flush  input  1  synchronous abort of any in-flight operation.
- busy  output  1  high while iterating; the upstream stage must hold the pipeline.
- done  output  1  one-cycle pulse, result valid.
- result  output  XLEN  quotient or remainder per op; holds until the next done.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, internal quotient/remainder/counter=0. Reset mid-operation discards the operation; no done follows.
- States: IDLE, DIVIDE.
- IDLE with start=1 in cycle N:
  - divisor==0: no iteration. done=1 in cycle N+1 with result = all-ones for DIV/DIVU, or dividend for REM/REMU.
  - signed op, dividend==0x80000000, divisor==all-ones (overflow): done=1 in cycle N+1 with result = 0x80000000 for DIV, or 0 for REM.
  - otherwise: latch |dividend| and |divisor| (absolute values only for DIV/REM). Latch the quotient sign (signs differ) and remainder sign (dividend sign). Clear the counter; state→DIVIDE.
- DIVIDE:
  - busy=1 in cycles N+1..N+32.
  - Each edge performs one restoring step: shift the remainder left, bringing in the dividend MSB. Subtract the divisor; if the difference is non-negative, keep it and shift in a quotient bit of 1, else restore and shift in 0. Increment the counter.
  - On the XLEN-th step edge:
    - result = quotient (DIV/DIVU) or remainder (REM/REMU);
    - for signed ops the value is negated if the latched sign is set;
    - done=1, busy=0, state→IDLE.
  - Normal latency: done in cycle N+XLEN+1, i.e. N+33 at the default.
- done is high for exactly one cycle; a start in the done cycle is accepted (state is already IDLE).
- start while busy=1 is ignored; operands are not re-sampled.
- flush=1:
  - next edge: state→IDLE, busy=0, no done; result keeps its old value.
  - flush and start in the same cycle: flush wins, start dropped.
- Arithmetic: the remainder register is XLEN+1 bits to hold the subtract sign. Negation is two's complement modulo 2^XLEN. Unsigned ops never negate.
- Invariants: busy and done are never simultaneously high; result changes only on the done edge or reset.

Test Plan:
- DIV 100/7 with start in cycle N → busy high N+1..N+32; done=1 only in N+33, result=14; REM same operands → result=2.
- Signed sign rules: DIV -100/7 → 0xFFFFFFF2 (-14); REM -100/7 → 0xFFFFFFFE (-2); REM 100/-7 → 2; DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
- Divide by zero: DIV 5/0 → done in N+1, result 0xFFFFFFFF, busy never high; REMU 5/0 → 5.
- Overflow: DIV 0x80000000/0xFFFFFFFF → done N+1, result 0x80000000; REM same operands → 0.
- Back-to-back and ignore:
  - start held high and operands changed during busy → no re-sample, single done with the first result;
  - start asserted in the done cycle → second done 33 cycles later with the correct value.
- Abort:
  - flush at cycle N+10 → busy=0 at N+11, no done, result unchanged; a following start computes correctly.
  - reset asserted asynchronously at N+20 → outputs 0 immediately; no done after release.
